matmul3_seq_ctrl: RTL



---
 rtl/matmul3_pkg.sv | 25 ++
 rtl/matmul3_mac.sv | 35 +++
 rtl/matmul3_seq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/matmul3_pkg.sv
// Shared types, sizes and index helpers for the sequential 3x3 matrix multiplier.
package matmul3_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_CALC,
    S_OUT
  } state_t;

  localparam int N     = 3;
  localparam int N_IN  = 18;
  localparam int N_OUT = 9;
  localparam int N_MAC = 27;

  // Operand buffer position of element [row][col] of a column-major 3x3 matrix.
  function automatic logic [4:0] col_major_idx(input logic [1:0] row, input logic [1:0] col);
    return 5'(col) * 5'(N) + 5'(row);
  endfunction

  // Result buffer position of element [row][col] of a row-major 3x3 matrix.
  function automatic logic [3:0] row_major_idx(input logic [1:0] row, input logic [1:0] col);
    return 4'(row) * 4'(N) + 4'(col);
  endfunction

endpackage

// File: rtl/matmul3_mac.sv
// Registered multiply-accumulate unit shared by all 27 products of the 3x3 multiply.
module matmul3_mac #(
  parameter int DW = 8,
  parameter int OW = 2*DW+3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          clr_acc,
  input  logic          en,
  output logic [OW-1:0] acc
);

  localparam int PW = 2*DW;

  logic [PW-1:0] prod_p0;

  // The product is zero-extended so the three-term sum can never wrap.
  function automatic logic [OW-1:0] zext_prod(input logic [PW-1:0] p);
    return {{(OW-PW){1'b0}}, p};
  endfunction

  assign prod_p0 = PW'(a) * PW'(b);

  // Start a new dot product on clr_acc, otherwise add the product into the running sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr_acc ? zext_prod(prod_p0) : acc + zext_prod(prod_p0);
    end
  end

endmodule

// File: rtl/matmul3_seq_ctrl.sv
// Sequential 3x3 matrix multiply controller: load 18 operands, run 27 MACs, stream 9 results.
module matmul3_seq_ctrl
  import matmul3_pkg::*;
#(
  parameter int DW = 8,
  parameter int OW = 2*DW+3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [4:0]    load_cnt;
  logic [1:0]    i_cnt, j_cnt, k_cnt;
  logic [3:0]    out_cnt;
  logic [DW-1:0] op_buf [N_IN];
  logic [OW-1:0] result [N_OUT];
  logic [OW-1:0] acc;
  logic          wr_vld_p1;
  logic [3:0]    wr_idx_p1;
  logic          calc_last;
  logic [DW-1:0] mac_a, mac_b;

  assign calc_last = (state_q == S_CALC) && (i_cnt == 2'(N-1)) &&
                     (j_cnt == 2'(N-1)) && (k_cnt == 2'(N-1));

  // A occupies buffer positions 0..8 and B positions 9..17, both column-major.
  assign mac_a = op_buf[col_major_idx(i_cnt, k_cnt)];
  assign mac_b = op_buf[5'(N*N) + col_major_idx(k_cnt, j_cnt)];

  matmul3_mac #(.DW(DW), .OW(OW)) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (mac_a),
    .b       (mac_b),
    .clr_acc (k_cnt == 2'd0),
    .en      ((state_q == S_CALC) && !abort),
    .acc     (acc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (load_cnt == 5'(N_IN-1))) state_d = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (calc_last) state_d = S_OUT;
      end
      S_OUT: begin
        busy = 1'b1;
        if (out_valid && out_ready && (out_cnt == 4'(N_OUT-1))) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
    if (abort) state_d = S_LOAD;
  end

  // Capture operands in arrival order; a handshake coinciding with abort is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
      for (int n = 0; n < N_IN; n++) op_buf[n] <= '0;
    end else if (abort) begin
      load_cnt <= '0;
    end else if ((state_q == S_LOAD) && in_valid) begin
      op_buf[load_cnt] <= in_data;
      load_cnt         <= (load_cnt == 5'(N_IN-1)) ? '0 : load_cnt + 5'd1;
    end
  end

  // Walk i,j,k with k fastest; counters idle at zero outside CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt <= '0;
      j_cnt <= '0;
      k_cnt <= '0;
    end else if (abort || (state_q != S_CALC)) begin
      i_cnt <= '0;
      j_cnt <= '0;
      k_cnt <= '0;
    end else if (k_cnt == 2'(N-1)) begin
      k_cnt <= '0;
      if (j_cnt == 2'(N-1)) begin
        j_cnt <= '0;
        i_cnt <= (i_cnt == 2'(N-1)) ? '0 : i_cnt + 2'd1;
      end else begin
        j_cnt <= j_cnt + 2'd1;
      end
    end else begin
      k_cnt <= k_cnt + 2'd1;
    end
  end

  // ---- stage p1: the accumulator holds the finished dot product one cycle after k=2 ----
  // Write the completed sum into the row-major result buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_p1 <= 1'b0;
      wr_idx_p1 <= '0;
      for (int n = 0; n < N_OUT; n++) result[n] <= '0;
    end else begin
      wr_vld_p1 <= (state_q == S_CALC) && (k_cnt == 2'(N-1)) && !abort;
      wr_idx_p1 <= row_major_idx(i_cnt, j_cnt);
      if (wr_vld_p1) result[wr_idx_p1] <= acc;
    end
  end

  // Registered output stream: present result[0] on entering OUT, advance on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else if (abort) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_cnt   <= '0;
    end else if (state_q == S_OUT) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= result[out_cnt];
        out_last  <= 1'b0;
      end else if (out_ready) begin
        if (out_cnt == 4'(N_OUT-1)) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_cnt   <= '0;
        end else begin
          out_cnt  <= out_cnt + 4'd1;
          out_data <= result[out_cnt + 4'd1];
          out_last <= (out_cnt == 4'(N_OUT-2));
        end
      end
    end
  end

endmodule
